// File: rtl/traffic_lite_pkg.sv
// traffic_lite shared types: state codes, dwell width, light decode.
// Imported by the controller top and its dwell timer.
package traffic_lite_pkg;

  localparam int DWELL_W = 8;

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

  typedef logic [1:0] state_t;

  localparam state_t NS_GREEN = 2'd0;
  localparam state_t NS_CLEAR = 2'd1;
  localparam state_t EW_GREEN = 2'd2;
  localparam state_t EW_CLEAR = 2'd3;

  typedef struct packed {
    logic ew;
    logic ns;
  } lites_t;

  // At most one green per state; clear states show none.
  function automatic lites_t decode(input state_t s);
    lites_t l;
    l = '0;
    unique case (1'b1)
      (s == NS_GREEN): l.ns = 1'b1;
      (s == EW_GREEN): l.ew = 1'b1;
      default:         l = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_lite_timer.sv
// traffic_lite dwell timer: counts cycles spent in the current state.
// Restart loads 1 so the first cycle in a state reads as 1.
module traffic_lite_timer
  import traffic_lite_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               restart,
  output logic [DWELL_W-1:0] count
);

  // Reload on reset or state change, else count up and stick at max.
  always_ff @(posedge clock) begin
    if (!reset_n || restart) begin
      count <= DWELL_ONE;
    end else if (count != DWELL_MAX) begin
      count <= count + DWELL_ONE;
    end
  end

endmodule

// File: rtl/traffic_lite.sv
// traffic_lite: two-way light controller with min green and clearance.
// Lights are registered copies of the state decode.
module traffic_lite
  import traffic_lite_pkg::*;
#(
  parameter int unsigned MIN_GREEN = 1,
  parameter int unsigned ALL_RED   = 0
) (
  input  logic EWCar,
  input  logic NSCar,
  output logic EWLite,
  output logic NSLite,
  input  logic clock,
  input  logic reset_n
);

  localparam logic [DWELL_W-1:0] MIN_G =
    DWELL_W'(MIN_GREEN);
  localparam logic [DWELL_W-1:0] CLR_N =
    DWELL_W'(ALL_RED);
  localparam bit HAS_CLEAR = (ALL_RED != 0);

  state_t             state;
  state_t             next;
  logic [DWELL_W-1:0] dwell;
  logic               restart;
  lites_t             lites_nx;

  assign restart  = (next != state);
  assign lites_nx = decode(next);

  traffic_lite_timer u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .restart (restart),
    .count   (dwell)
  );

  // Leave a green only on a cross request after the minimum hold.
  always_comb begin
    next = state;
    unique case (state)
      NS_GREEN: begin
        if (EWCar && dwell >= MIN_G) begin
          next = HAS_CLEAR ? NS_CLEAR : EW_GREEN;
        end
      end
      NS_CLEAR: begin
        if (dwell >= CLR_N) next = EW_GREEN;
      end
      EW_GREEN: begin
        if (NSCar && dwell >= MIN_G) begin
          next = HAS_CLEAR ? EW_CLEAR : NS_GREEN;
        end
      end
      EW_CLEAR: begin
        if (dwell >= CLR_N) next = NS_GREEN;
      end
    endcase
  end

  // State register; reset wins over any pending transition.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= NS_GREEN;
    end else begin
      state <= next;
    end
  end

  // Lights track the state they will show, so they match it every cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      EWLite <= 1'b0;
      NSLite <= 1'b1;
    end else begin
      EWLite <= lites_nx.ew;
      NSLite <= lites_nx.ns;
    end
  end

endmodule

// File: tb/tb_traffic_lite.sv
// traffic_lite bench: vector table on defaults plus two
// hand-written sequences for min green / clearance settings.
module tb_traffic_lite;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic a_ew, a_ns, a_rst, a_ewl, a_nsl;
  logic b_ew, b_ns, b_rst, b_ewl, b_nsl;
  logic c_ew, c_ns, c_rst, c_ewl, c_nsl;

  traffic_lite u_a (
    .EWCar(a_ew), .NSCar(a_ns),
    .EWLite(a_ewl), .NSLite(a_nsl),
    .clock(clock), .reset_n(a_rst)
  );

  traffic_lite #(.MIN_GREEN(3), .ALL_RED(2)) u_b (
    .EWCar(b_ew), .NSCar(b_ns),
    .EWLite(b_ewl), .NSLite(b_nsl),
    .clock(clock), .reset_n(b_rst)
  );

  traffic_lite #(.MIN_GREEN(4), .ALL_RED(0)) u_c (
    .EWCar(c_ew), .NSCar(c_ns),
    .EWLite(c_ewl), .NSLite(c_nsl),
    .clock(clock), .reset_n(c_rst)
  );

  typedef struct {
    logic rst_n;
    logic ew;
    logic ns;
    logic x_ew;
    logic x_ns;
  } vec_t;

  vec_t tab[15];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic ewl, input logic nsl,
                     input logic x_ew, input logic x_ns);
    n_chk++;
    if ({ewl, nsl} !== {x_ew, x_ns}) begin
      n_fail++;
      $display("FAIL %s: got ew=%b ns=%b want ew=%b ns=%b",
               name, ewl, nsl, x_ew, x_ns);
    end
    n_chk++;
    if (ewl === 1'b1 && nsl === 1'b1) begin
      n_fail++;
      $display("FAIL %s_excl: got both lights 1 want at most one",
               name);
    end
  endtask

  // Drive one DUT before an edge, check its lights just after it.
  task automatic step(input int d, input logic r,
                      input logic e, input logic n,
                      input logic xe, input logic xn,
                      input string name);
    @(negedge clock);
    case (d)
      0: begin a_rst = r; a_ew = e; a_ns = n; end
      1: begin b_rst = r; b_ew = e; b_ns = n; end
      default: begin c_rst = r; c_ew = e; c_ns = n; end
    endcase
    @(posedge clock);
    #1;
    case (d)
      0: chk(name, a_ewl, a_nsl, xe, xn);
      1: chk(name, b_ewl, b_nsl, xe, xn);
      default: chk(name, c_ewl, c_nsl, xe, xn);
    endcase
  endtask

  initial begin
    a_rst = 0; a_ew = 0; a_ns = 0;
    b_rst = 0; b_ew = 0; b_ns = 0;
    c_rst = 0; c_ew = 0; c_ns = 0;

    // rst_n, ew, ns -> expected ew light, ns light (defaults)
    tab[0]  = '{0, 0, 0, 0, 1};
    tab[1]  = '{1, 0, 0, 0, 1};
    tab[2]  = '{1, 0, 0, 0, 1};
    tab[3]  = '{1, 0, 0, 0, 1};
    tab[4]  = '{1, 1, 0, 1, 0};
    tab[5]  = '{1, 1, 0, 1, 0};
    tab[6]  = '{1, 0, 0, 1, 0};
    tab[7]  = '{1, 1, 1, 0, 1};
    tab[8]  = '{1, 1, 1, 1, 0};
    tab[9]  = '{1, 1, 1, 0, 1};
    tab[10] = '{1, 1, 1, 1, 0};
    tab[11] = '{0, 0, 0, 0, 1};
    tab[12] = '{0, 1, 0, 0, 1};
    tab[13] = '{1, 0, 1, 0, 1};
    tab[14] = '{1, 1, 0, 1, 0};

    for (int i = 0; i < 15; i++) begin
      step(0, tab[i].rst_n, tab[i].ew, tab[i].ns,
           tab[i].x_ew, tab[i].x_ns, $sformatf("a_vec%0d", i));
    end

    // MIN_GREEN=3, ALL_RED=2
    step(1, 0, 0, 0, 0, 1, "b_rst");
    step(1, 1, 1, 0, 0, 1, "b_ns_d1");
    step(1, 1, 1, 0, 0, 1, "b_ns_d2");
    step(1, 1, 1, 0, 0, 0, "b_clr1");
    step(1, 1, 1, 1, 0, 0, "b_clr2_ign");
    step(1, 1, 1, 1, 1, 0, "b_ew_on");
    step(1, 1, 0, 1, 1, 0, "b_ew_d1");
    step(1, 1, 0, 1, 1, 0, "b_ew_d2");
    step(1, 1, 0, 1, 0, 0, "b_ewclr1");
    step(1, 0, 0, 1, 0, 1, "b_rst_in_clr");
    step(1, 1, 0, 0, 0, 1, "b_idle");
    step(1, 1, 1, 0, 0, 1, "b_ns_d2b");
    step(1, 1, 1, 0, 0, 0, "b_clr_again");

    // MIN_GREEN=4, ALL_RED=0
    step(2, 0, 0, 0, 0, 1, "c_rst");
    step(2, 1, 1, 0, 0, 1, "c_pulse1");
    step(2, 1, 1, 0, 0, 1, "c_pulse2");
    step(2, 1, 0, 0, 0, 1, "c_drop1");
    step(2, 1, 0, 0, 0, 1, "c_drop2");
    for (int i = 0; i < 300; i++) begin
      step(2, 1, 0, 1, 0, 1, "c_hold");
    end
    step(2, 1, 1, 0, 1, 0, "c_sat_switch");
    step(2, 1, 0, 1, 1, 0, "c_ew_d1");
    step(2, 0, 0, 1, 0, 1, "c_rst_mid_dwell");
    step(2, 1, 1, 1, 0, 1, "c_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_lite.md
TRAFFIC_LITE -- requirements
Module: traffic_lite

Interface
REQ-001 Parameter MIN_GREEN, default 1 -- minimum consecutive cycles a green phase is held before a switch is allowed; legal range 1..255.
REQ-002 Parameter ALL_RED, default 0 -- clearance cycles with both lights off between phases; legal range 0..255.
REQ-003 Port clock  input  1  -- single clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  -- synchronous, active-low reset.
REQ-005 Port EWCar  input  1  -- car waiting on east-west approach, sampled each rising edge.
REQ-006 Port NSCar  input  1  -- car waiting on north-south approach, sampled each rising edge.
REQ-007 Port EWLite  output  1  -- east-west green when 1.
REQ-008 Port NSLite  output  1  -- north-south green when 1.
REQ-009 Port order for positional instantiation SHALL be EWCar, NSCar, EWLite, NSLite, clock, reset_n.

Function
REQ-010 States SHALL be NS_GREEN, NS_CLEAR, EW_GREEN, EW_CLEAR.
REQ-011 Outputs SHALL be Moore, registered, decoded from state only: NS_GREEN -> NSLite=1, EWLite=0; EW_GREEN -> EWLite=1, NSLite=0; both CLEAR states -> both 0.
REQ-012 EWLite and NSLite SHALL never be 1 in the same cycle.
REQ-013 A dwell counter SHALL reset to 1 on entry to every state and increment each cycle in that state, saturating at 255.
REQ-014 NS_GREEN SHALL stay while EWCar=0; when EWCar=1 and dwell >= MIN_GREEN, next state SHALL be NS_CLEAR if ALL_RED>0, else EW_GREEN.
REQ-015 EW_GREEN SHALL behave symmetrically: leave on NSCar=1 and dwell >= MIN_GREEN, to EW_CLEAR if ALL_RED>0, else NS_GREEN.
REQ-016 NS_CLEAR SHALL go to EW_GREEN after exactly ALL_RED cycles; EW_CLEAR SHALL go to NS_GREEN after exactly ALL_RED cycles; car inputs are ignored in CLEAR states.
REQ-017 With defaults, a request SHALL switch the lights at the first rising edge at which it is sampled high, so outputs change one cycle after the request is registered.
REQ-018 With both cars requesting, the lights SHALL alternate, each green lasting MIN_GREEN cycles followed by ALL_RED clear cycles.
REQ-019 With no requests, the current green SHALL be held indefinitely.
REQ-020 A request that drops before dwell reaches MIN_GREEN SHALL be forgotten; requests are not latched.

Reset
REQ-021 reset_n=0 at a rising edge SHALL force NS_GREEN and dwell=1; NSLite=1 and EWLite=0 from the next cycle.
REQ-022 Reset SHALL take priority over every transition, including mid-CLEAR and mid-dwell.
REQ-023 While reset_n=0, outputs SHALL remain NSLite=1 and EWLite=0.

Structure
REQ-024 Package traffic_lite_pkg SHALL hold the state enumeration and the 8-bit dwell-width constant.
REQ-025 The dwell counter SHALL be a sub-module traffic_lite_timer with restart, increment/saturate, and count output.
REQ-026 The top level SHALL contain only the state register, next-state logic and output decode.

Verification
REQ-027 Reset, then EWCar=0, NSCar=0 for 3 cycles -> NSLite=1, EWLite=0 throughout.
REQ-028 Defaults, from NS_GREEN set EWCar=1, NSCar=0 -> EWLite=1, NSLite=0 one edge later, held while NSCar=0.
REQ-029 Defaults, EWCar=1, NSCar=1 for 4 cycles -> lights toggle every cycle, never both 1.
REQ-030 MIN_GREEN=3, ALL_RED=2, EWCar=1 from reset -> NS green 3 cycles, both off 2 cycles, then EWLite=1.
REQ-031 Assert reset_n=0 during EW_CLEAR -> next cycle NSLite=1, EWLite=0.
REQ-032 MIN_GREEN=4, pulse EWCar=1 for 2 cycles then 0 -> no switch; NSLite remains 1.
